// File: rtl/av_st_arb_pkg.sv
// Shared types and default widths for the two-source Avalon-ST packet arbiter.
// The beat struct is the unit moved through the input mux and the output stage.
package av_st_arb_pkg;

    localparam int DATA_WIDTH  = 24;
    localparam int EMPTY_WIDTH = 2;
    localparam int CNT_WIDTH   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
    } beat_t;

    // One stage entry: the beat plus the index of the source that produced it.
    typedef struct packed {
        logic  channel;
        beat_t beat;
    } stage_entry_t;

endpackage

// File: rtl/av_st_pipe_stage.sv
// One-entry registered output stage. It accepts a new entry whenever it is
// empty or the sink is draining it in the same cycle.
module av_st_pipe_stage #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_payload,
    output logic             ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_payload
);

    assign ready = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
        end else if (ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_payload <= in_payload;
            end
        end
    end

endmodule

// File: rtl/av_st_packet_arbiter.sv
// Round-robin, packet-granular arbiter sharing one Avalon-ST sink between two
// sources, with a registered output stage and a saturating stray-beat counter.
module av_st_packet_arbiter
    import av_st_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = av_st_arb_pkg::DATA_WIDTH,
    parameter int EMPTY_WIDTH = av_st_arb_pkg::EMPTY_WIDTH,
    parameter int CNT_WIDTH   = av_st_arb_pkg::CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,

    output logic                   in0_ready,
    input  logic                   in0_valid,
    input  logic [DATA_WIDTH-1:0]  in0_data,
    input  logic                   in0_startofpacket,
    input  logic                   in0_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] in0_empty,

    output logic                   in1_ready,
    input  logic                   in1_valid,
    input  logic [DATA_WIDTH-1:0]  in1_data,
    input  logic                   in1_startofpacket,
    input  logic                   in1_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] in1_empty,

    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_channel,

    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   drop_count
);

    localparam int STAGE_W = $bits(stage_entry_t);

    state_t       state, state_next;
    logic         grant, grant_next;
    logic         ptr, ptr_next;
    logic         load;
    logic         cand0, cand1;
    logic         drop0, drop1;
    logic         accept;
    beat_t        beat0, beat1;
    stage_entry_t sel_entry, out_entry;
    logic         sel_valid;

    always_comb begin
        beat0.data  = in0_data;
        beat0.sop   = in0_startofpacket;
        beat0.eop   = in0_endofpacket;
        beat0.empty = in0_empty;
        beat1.data  = in1_data;
        beat1.sop   = in1_startofpacket;
        beat1.eop   = in1_endofpacket;
        beat1.empty = in1_empty;

        cand0 = in0_valid && in0_startofpacket;
        cand1 = in1_valid && in1_startofpacket;
        drop0 = (state == IDLE) && in0_valid && !in0_startofpacket;
        drop1 = (state == IDLE) && in1_valid && !in1_startofpacket;

        sel_entry.channel = grant;
        sel_entry.beat    = grant ? beat1 : beat0;
        sel_valid         = grant ? in1_valid : in0_valid;
        accept            = (state == GRANT) && sel_valid && load;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        in0_ready  = drop0;
        in1_ready  = drop1;

        unique case (state)
            IDLE: begin
                if (enable && (cand0 || cand1)) begin
                    state_next = GRANT;
                    grant_next = ptr ? cand1 : !cand0;
                end
            end
            GRANT: begin
                in0_ready = !grant && load;
                in1_ready = grant && load;
                if (accept && sel_entry.beat.eop) begin
                    state_next = IDLE;
                    ptr_next   = !grant;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

    // Add up to two dropped beats per cycle, clamping at the all-ones value.
    logic [CNT_WIDTH:0] drop_sum;
    always_comb begin
        drop_sum = {1'b0, drop_count} + (CNT_WIDTH + 1)'(drop0) + (CNT_WIDTH + 1)'(drop1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_sum[CNT_WIDTH]) begin
            drop_count <= '1;
        end else begin
            drop_count <= drop_sum[CNT_WIDTH-1:0];
        end
    end

    av_st_pipe_stage #(
        .WIDTH (STAGE_W)
    ) u_out_stage (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (accept),
        .in_payload  (sel_entry),
        .ready       (load),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_payload (out_entry)
    );

    assign out_data          = out_entry.beat.data;
    assign out_startofpacket = out_entry.beat.sop;
    assign out_endofpacket   = out_entry.beat.eop;
    assign out_empty         = out_entry.beat.empty;
    assign out_channel       = out_entry.channel;
    assign busy              = (state == GRANT);

endmodule
